// File: rtl/ucomb_seq.sv
// ucomb_seq: vector sequencer for the universal-gate combinational block.
// Applies an arithmetic sweep of 27-bit vectors. It waits SETTLE_CYCLES
// after each vector, then captures the block's 6-bit response. Responses
// are folded into a Galois MISR signature.
// Optional build macro UCOMB_SEQ_EXPECT_EN adds an expected-signature
// compare (exp_sig input, pass output).
module ucomb_seq #(
  parameter int unsigned         SETTLE_CYCLES = 2,
  parameter int unsigned         COUNT_W       = 16,
  parameter int unsigned         MISR_W        = 16,
  parameter logic [MISR_W-1:0]   MISR_POLY     = 16'h002D,
  parameter logic [MISR_W-1:0]   MISR_SEED     = '1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start,
  input  logic                abort,
  input  logic [26:0]         base_vec,
  input  logic [26:0]         step_vec,
  input  logic [COUNT_W-1:0]  count,
  output logic [26:0]         vec_out,
  input  logic [5:0]          res_in,
  output logic [5:0]          last_res,
  output logic [MISR_W-1:0]   signature,
  output logic                busy,
`ifdef UCOMB_SEQ_EXPECT_EN
  input  logic [MISR_W-1:0]   exp_sig,
  output logic                pass,
`endif
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned SET_W       = $clog2(SETTLE_CYCLES + 2);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  // With no settle time a freshly applied vector is captured on the next edge.
  localparam state_t RUN_ENTRY = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;

  // One Galois MISR step: shift left, fold the polynomial on a carried-out
  // one, then inject the response into the low bits.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic [5:0]        res);
    logic [MISR_W-1:0] fb;
    fb = sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}};
    return {sig[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(res);
  endfunction

  state_t               state_r, state_nxt_s;
  logic [26:0]          vec_r, vec_nxt_s;
  logic [26:0]          step_r, step_nxt_s;
  logic [COUNT_W-1:0]   rem_r, rem_nxt_s;
  logic [SET_W-1:0]     settle_r, settle_nxt_s;
  logic [MISR_W-1:0]    sig_r, sig_nxt_s;
  logic [5:0]           res_r, res_nxt_s;
  logic                 busy_r, done_r;
  logic [MISR_W-1:0]    cap_sig_s;
`ifdef UCOMB_SEQ_EXPECT_EN
  logic                 pass_r, pass_nxt_s;
`endif

  assign cap_sig_s = misr_step(sig_r, res_in);

  // Next-state and datapath update; every register holds unless changed.
  always_comb begin
    state_nxt_s  = state_r;
    vec_nxt_s    = vec_r;
    step_nxt_s   = step_r;
    rem_nxt_s    = rem_r;
    settle_nxt_s = settle_r;
    sig_nxt_s    = sig_r;
    res_nxt_s    = res_r;
`ifdef UCOMB_SEQ_EXPECT_EN
    pass_nxt_s   = pass_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          sig_nxt_s = MISR_SEED;
          if (count != {COUNT_W{1'b0}}) begin
            vec_nxt_s    = base_vec;
            step_nxt_s   = step_vec;
            rem_nxt_s    = count;
            settle_nxt_s = SETTLE_LOAD;
            state_nxt_s  = RUN_ENTRY;
`ifdef UCOMB_SEQ_EXPECT_EN
            pass_nxt_s   = 1'b0;
`endif
          end else begin
            // Empty run: the final signature is the seed itself.
            state_nxt_s  = DONE;
`ifdef UCOMB_SEQ_EXPECT_EN
            pass_nxt_s   = (MISR_SEED == exp_sig);
`endif
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          settle_nxt_s = settle_r - SET_W'(1);
          if (settle_r <= SET_W'(1)) begin
            state_nxt_s = CAPTURE;
          end else begin
            state_nxt_s = SETTLE;
          end
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else begin
          res_nxt_s = res_in;
          sig_nxt_s = cap_sig_s;
          if (rem_r == COUNT_W'(1)) begin
            state_nxt_s = DONE;
`ifdef UCOMB_SEQ_EXPECT_EN
            pass_nxt_s  = (cap_sig_s == exp_sig);
`endif
          end else begin
            rem_nxt_s    = rem_r - COUNT_W'(1);
            vec_nxt_s    = vec_r + step_r;
            settle_nxt_s = SETTLE_LOAD;
            state_nxt_s  = RUN_ENTRY;
          end
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; busy/done are derived from the next state
  // so that they are registered and line up with the state they describe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      vec_r    <= 27'd0;
      step_r   <= 27'd0;
      rem_r    <= {COUNT_W{1'b0}};
      settle_r <= {SET_W{1'b0}};
      sig_r    <= {MISR_W{1'b0}};
      res_r    <= 6'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef UCOMB_SEQ_EXPECT_EN
      pass_r   <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      vec_r    <= vec_nxt_s;
      step_r   <= step_nxt_s;
      rem_r    <= rem_nxt_s;
      settle_r <= settle_nxt_s;
      sig_r    <= sig_nxt_s;
      res_r    <= res_nxt_s;
      busy_r   <= (state_nxt_s == SETTLE) || (state_nxt_s == CAPTURE);
      done_r   <= (state_nxt_s == DONE);
`ifdef UCOMB_SEQ_EXPECT_EN
      pass_r   <= pass_nxt_s;
`endif
    end
  end

  assign vec_out   = vec_r;
  assign last_res  = res_r;
  assign signature = sig_r;
  assign busy      = busy_r;
  assign done      = done_r;
`ifdef UCOMB_SEQ_EXPECT_EN
  assign pass      = pass_r;
`endif

endmodule
